fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request this cycle.
REQ-005 imem_addr  output  32  read address, valid when imem_req=1.
REQ-006 imem_rdata  input  32  read data, valid exactly one cycle after the accepted imem_req.
REQ-007 redirect_valid  input  1  branch/jump redirect from execute.
REQ-008 redirect_pc  input  32  redirect target, sampled when redirect_valid=1.
REQ-009 dec_valid  output  1  head instruction available to decode.
REQ-010 dec_ready  input  1  decode accepts the head instruction this cycle.
REQ-011 dec_instr  output  32  head instruction word.
REQ-012 dec_pc  output  32  address of the head instruction.
REQ-013 dec_pc_plus4  output  32  dec_pc+4, modulo 2^32.
REQ-014 op  output  7  dec_instr[6:0], for the control unit.
REQ-015 funct3  output  3  dec_instr[14:12].
REQ-016 funct7  output  7  dec_instr[31:25].

Function
REQ-017 Block SHALL hold a 2-entry instruction queue; each entry is {instr[31:0], pc[31:0]}.
REQ-018 Fetch PC register SHALL advance by 4 (modulo 2^32) on every issued request.
REQ-019 imem_req SHALL be 1 iff no redirect this cycle and (queue occupancy + in-flight responses) < 2, counting a pop in the same cycle as freeing a slot.
REQ-020 At most one request SHALL be in flight; the response is written to the queue tail in the cycle imem_rdata is valid, together with its request address.
REQ-021 dec_valid SHALL equal (occupancy != 0); dec_instr/dec_pc/op/funct3/funct7 are driven from the head entry and are don't-care when dec_valid=0.
REQ-022 A pop SHALL occur iff dec_valid && dec_ready; dec_ready with dec_valid=0 has no effect.
REQ-023 A push and a pop in the same cycle SHALL leave occupancy unchanged, with order preserved.
REQ-024 When full (2 entries), the block SHALL not issue requests; no queue entry is ever overwritten or lost.
REQ-025 Fetch latency: a request issued in cycle N, with the queue empty, SHALL give dec_valid=1 in cycle N+2.
REQ-026 On redirect_valid=1: the queue is cleared, any in-flight response is discarded, the fetch PC becomes redirect_pc, and imem_req=0 that cycle.
REQ-027 The first request after a redirect SHALL be issued in the next cycle with imem_addr=redirect_pc.
REQ-028 Redirect SHALL take priority over a simultaneous pop and push; a pop in the redirect cycle is still treated as consumed by decode.
REQ-029 Back-to-back redirects SHALL each apply; the last one wins.
REQ-030 With dec_ready held at 1 and no redirects, sustained throughput SHALL be one instruction per cycle.

Reset
REQ-031 While rst=0: fetch PC = RESET_PC, queue empty, in-flight flag cleared, imem_req=0, dec_valid=0, imem_addr=RESET_PC.
REQ-032 Reset SHALL act immediately, independent of clk, and SHALL discard any in-flight response.
REQ-033 The first request SHALL be issued in the first rising edge cycle after rst deasserts, with imem_addr=RESET_PC.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined: the block adds output perf_fetch_cnt[31:0].
REQ-035 perf_fetch_cnt counts pops, resets to 0, wraps at 2^32, and is not cleared by redirect.
REQ-036 Macro FETCH_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-037 Release reset, memory returns 32'h00500093 for address 0 -> imem_addr=0 in cycle 0; dec_valid=1 in cycle 2 with dec_instr=32'h00500093, op=7'h13, funct3=0, dec_pc=0, dec_pc_plus4=4.
REQ-038 dec_ready=1 held, 8 cycles -> dec_pc sequence 0,4,8,...,28 on consecutive cycles with no bubbles after the first.
REQ-039 dec_ready=0 for 5 cycles -> queue holds 2 entries (pc 0,4), imem_req=0 while full; on dec_ready=1, pcs 0,4,8 delivered in order with no duplicates or gaps.
REQ-040 Redirect to 32'h0000_0100 while one response is in flight and queue has 1 entry -> dec_valid=0 next cycle, imem_addr=32'h100, stale data never appears, next dec_pc=32'h100.
REQ-041 Assert rst mid-stream with full queue -> dec_valid=0 and imem_req=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
REQ-042 With FETCH_PERF_CNT_EN: 10 pops, a redirect, then 3 more pops -> perf_fetch_cnt=13.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 2-entry {instr,pc} queue feeding decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt pop counter output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic        infl_q, infl_d;
  logic [1:0]  cnt_q, cnt_d, occ, wr_idx;
  logic [63:0] e0_q, e0_d, e1_q, e1_d;
  logic        pop, push;

  assign dec_valid    = cnt_q != 2'd0;
  assign pop          = dec_valid & dec_ready;
  assign push         = infl_q & ~redirect_valid;
  // slots committed after this cycle; a pop frees its slot immediately
  assign occ          = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign wr_idx       = cnt_q - {1'b0, pop};
  assign imem_req     = rst & ~redirect_valid & (occ < 2'd2);
  assign imem_addr    = pc_q;
  assign dec_instr    = e0_q[63:32];
  assign dec_pc       = e0_q[31:0];
  assign dec_pc_plus4 = e0_q[31:0] + 32'd4;
  assign op           = e0_q[38:32];
  assign funct3       = e0_q[46:44];
  assign funct7       = e0_q[63:57];

  always_comb begin
    pc_d     = redirect_valid ? redirect_pc : imem_req ? pc_q + 32'd4 : pc_q;
    req_pc_d = imem_req ? pc_q : req_pc_q;
    infl_d   = imem_req;
    cnt_d    = redirect_valid ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    e0_d     = (push && wr_idx == 2'd0) ? {imem_rdata, req_pc_q} : pop ? e1_q : e0_q;
    e1_d     = (push && wr_idx == 2'd1) ? {imem_rdata, req_pc_q} : e1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      infl_q   <= 1'b0;
      cnt_q    <= 2'd0;
      e0_q     <= 64'd0;
      e1_q     <= 64'd0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;
  assign perf_fetch_cnt = perf_q;
  // counts decode consumption, so a pop in a redirect cycle still counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= 32'd0;
    else      perf_q <= perf_q + {31'd0, pop};
  end
`endif
endmodule
